// File: rtl/mem_responder.sv
// Byte-addressable big-endian data memory answering MOV/MOC requests after WAIT_STATES wait cycles.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned accesses on ERR instead of aligning them.
module mem_responder #(
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        ERR
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            rw_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic            err_q;

    logic            req_rw;
    logic [1:0]      req_size;
    logic [AW-1:0]   req_addr;
    logic [31:0]     req_data;
    logic            is_word, is_half;
    logic [AW-1:0]   base, a0, a1, a2, a3;
    logic            blocked;
    logic            do_access;
    logic [31:0]     rd_word;
    logic [7:0]      mem [DEPTH];
    logic            unused_addr;

    assign unused_addr = ^ADDR[31:AW];

    // In IDLE the request is taken straight from the ports so WAIT_STATES=0 completes on the capture edge.
    always_comb begin
        req_rw   = (state == S_IDLE) ? RW             : rw_q;
        req_size = (state == S_IDLE) ? SIZE           : size_q;
        req_addr = (state == S_IDLE) ? ADDR[AW-1:0]   : addr_q;
        req_data = (state == S_IDLE) ? DataIn         : data_q;
    end

    assign is_word = req_size[1];
    assign is_half = (req_size == 2'b01);

`ifdef MEM_ALIGN_CHECK_EN
    assign base    = req_addr;
    assign blocked = (is_word && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]);
`else
    always_comb begin
        base = req_addr;
        if (is_word)
            base = {req_addr[AW-1:2], 2'b00};
        else if (is_half)
            base = {req_addr[AW-1:1], 1'b0};
    end
    assign blocked = 1'b0;
`endif

    // Each byte lane wraps independently modulo DEPTH.
    assign a0 = base;
    assign a1 = base + AW'(1);
    assign a2 = base + AW'(2);
    assign a3 = base + AW'(3);

    always_comb begin
        if (is_word)
            rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};
        else if (is_half)
            rd_word = {16'h0000, mem[a0], mem[a1]};
        else
            rd_word = {24'h000000, mem[a0]};
    end

    assign do_access = RST_N && (state != S_DONE) && (state_nxt == S_DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && MOV)
                cnt <= 4'(WAIT_STATES);
            else if (state == S_WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (MOV) state_nxt = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (!MOV)
                    state_nxt = S_IDLE;
                else if (cnt == 4'd0)
                    state_nxt = S_DONE;
            end
            S_DONE: if (!MOV) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        MOC = (state == S_DONE);
        ERR = (state == S_DONE) && err_q;
    end

    always_ff @(posedge CLK) begin
        if (state == S_IDLE && MOV) begin
            rw_q   <= RW;
            size_q <= SIZE;
            addr_q <= ADDR[AW-1:0];
            data_q <= DataIn;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DataOut <= 32'h0;
            err_q   <= 1'b0;
        end else if (do_access) begin
            err_q <= blocked;
            if (req_rw)
                DataOut <= blocked ? 32'h0 : rd_word;
        end
    end

    // Memory contents survive reset by design.
    always_ff @(posedge CLK) begin
        if (do_access && !req_rw && !blocked) begin
            if (is_word) begin
                mem[a0] <= req_data[31:24];
                mem[a1] <= req_data[23:16];
                mem[a2] <= req_data[15:8];
                mem[a3] <= req_data[7:0];
            end else if (is_half) begin
                mem[a0] <= req_data[15:8];
                mem[a1] <= req_data[7:0];
            end else begin
                mem[a0] <= req_data[7:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver queues expected completions, monitor checks them on MOC.
// Expectations for the misaligned cases follow MEM_ALIGN_CHECK_EN when it is defined.
module tb_mem_responder;
    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mov;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        moc;
    logic        err;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_rd = 32'h0;
    logic        moc_prev = 1'b0;
    logic        done = 1'b0;

    mem_responder #(.DEPTH(512), .WAIT_STATES(WS)) dut (
        .CLK(clk), .RST_N(rst_n), .MOV(mov), .RW(rw), .SIZE(size), .ADDR(addr),
        .DataIn(data_in), .DataOut(data_out), .MOC(moc), .ERR(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising MOC must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!done && moc && !moc_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_moc", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("err_flag", {31'b0, err}, {31'b0, e.err});
                check(e.rd ? "read_data" : "dataout_hold", data_out, e.data);
            end
        end
        moc_prev <= moc;
    end

    task automatic access(input logic rd, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.rd   = rd;
        e.err  = exp_err;
        e.data = rd ? exp_rd : last_rd;
        if (rd) last_rd = exp_rd;
        sb.push_back(e);
        @(negedge clk);
        rw = rd; size = sz; addr = a; data_in = wd; mov = 1'b1;
        @(posedge clk);
        #1;
        rw = ~rd; size = ~sz; addr = ~a; data_in = ~wd;
        n = 0;
        while (!moc && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("moc_latency", n, WS + 1);
        @(negedge clk);
        mov = 1'b0;
        @(posedge clk);
        #1;
        check("moc_drop", {31'b0, moc}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mov = 1'b1; rw = 1'b1; size = 2'b10; addr = 32'h0; data_in = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_moc", {31'b0, moc}, 32'd0);
        check("reset_dataout", data_out, 32'h0);
        check("reset_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        mov = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_moc", {31'b0, moc}, 32'd0);

        access(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        access(1'b1, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        access(1'b1, 2'b00, 32'h11, 32'h0, 32'h000000AD, 1'b0);
        access(1'b1, 2'b01, 32'h12, 32'h0, 32'h0000BEEF, 1'b0);
        access(1'b0, 2'b00, 32'h13, 32'hAABBCC55, 32'h0, 1'b0);
        access(1'b1, 2'b11, 32'h10, 32'h0, 32'hDEADBE55, 1'b0);

        access(1'b0, 2'b10, 32'h200, 32'h11223344, 32'h0, 1'b0);
        access(1'b1, 2'b10, 32'h0, 32'h0, 32'h11223344, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        access(1'b0, 2'b10, 32'h1FC, 32'h99887766, 32'h0, 1'b0);
`else
        access(1'b0, 2'b10, 32'h1FE, 32'h99887766, 32'h0, 1'b0);
`endif
        access(1'b1, 2'b10, 32'h1FC, 32'h0, 32'h99887766, 1'b0);

        // Abort by dropping MOV one cycle after capture.
        access(1'b0, 2'b10, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        @(negedge clk);
        rw = 1'b0; size = 2'b10; addr = 32'h20; data_in = 32'hFFFFFFFF; mov = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mov = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_moc", {31'b0, moc}, 32'd0);
        access(1'b1, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset while waiting: access abandoned, DataOut cleared.
        @(negedge clk);
        rw = 1'b0; size = 2'b10; addr = 32'h20; data_in = 32'hFFFFFFFF; mov = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        mov = 1'b0;
        #1;
        check("midreset_dataout", data_out, 32'h0);
        last_rd = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midreset_no_moc", {31'b0, moc}, 32'd0);
        access(1'b1, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
        access(1'b0, 2'b10, 32'h22, 32'h12345678, 32'h0, 1'b1);
        access(1'b1, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        access(1'b1, 2'b10, 32'h22, 32'h0, 32'h0, 1'b1);
        access(1'b1, 2'b01, 32'h21, 32'h0, 32'h0, 1'b1);
`else
        access(1'b1, 2'b10, 32'h22, 32'h0, 32'hCAFEF00D, 1'b0);
        access(1'b0, 2'b10, 32'h22, 32'h12345678, 32'h0, 1'b0);
        access(1'b1, 2'b10, 32'h20, 32'h0, 32'h12345678, 1'b0);
        access(1'b1, 2'b01, 32'h21, 32'h0, 32'h00001234, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
